alarm_time_setter: RTL and testbench
====================================

# alarm_time_setter

User-facing editor that produces the stored alarm time consumed by the alarm comparator. It takes debounced button pulses, walks the user through editing the hour and minute fields in BCD with 24-hour limits, and commits the result with a one-cycle load strobe. It also keeps an armed flag that gates alarm sounding. It sits between the button front-end and the alarm comparator in the watch controller.

## Interface

- BLINK_DIV, 500: clk cycles per half-period of the edit blink indicator; must be at least 2.
- TIMEOUT, 10000: clk cycles with no button pulse before an edit session is abandoned.

- clk  in  1  system clock; all state updates on the rising edge.
- resetN  in  1  asynchronous, active-low reset.
- modeBtn  in  1  one-cycle pulse; enters edit, or switches the edited field.
- incBtn  in  1  one-cycle pulse; increments the edited field.
- decBtn  in  1  one-cycle pulse; decrements the edited field.
- setBtn  in  1  one-cycle pulse; commits in edit, toggles armed in idle.
- alarmHour1  out  4  committed hour tens digit, BCD 0–2.
- alarmHour0  out  4  committed hour ones digit, BCD.
- alarmMin1  out  4  committed minute tens digit, BCD 0–5.
- alarmMin0  out  4  committed minute ones digit, BCD.
- alarmLoad  out  1  one-cycle strobe; the committed digits are new and valid.
- armed  out  1  alarm enabled.
- editing  out  1  high while in EDIT_HOUR or EDIT_MIN.
- fieldSel  out  1  field being edited: 0 = hour, 1 = minute; 0 outside edit.
- blink  out  1  blink phase for the edited field display; 0 outside edit.

## Operation

- Button inputs are already synchronous, debounced single-cycle pulses; the block does no debouncing.
- Storage:
  - working registers wH1, wH0, wM1, wM0;
  - committed registers drive the alarmHour*/alarmMin* outputs directly.
- States: IDLE, EDIT_HOUR, EDIT_MIN, COMMIT.
- IDLE
  - modeBtn: copy the committed time into the working registers, go to EDIT_HOUR.
  - setBtn: toggle armed.
  - incBtn/decBtn: ignored.
- EDIT_HOUR and EDIT_MIN, per-cycle priority:
  1. modeBtn and setBtn together: abort to IDLE. Working value is discarded; committed value and armed are unchanged.
  2. setBtn: go to COMMIT.
  3. modeBtn: switch to the other edit state.
  4. incBtn xor decBtn: adjust the current field. incBtn and decBtn together is a no-op.
- Hour field arithmetic (00–23, BCD):
  - inc: 09→10, 19→20, 23→00.
  - dec: 00→23, 20→19, 10→09.
- Minute field arithmetic (00–59, BCD):
  - inc: carry from ones to tens, 59→00.
  - dec: 00→59, x0→(x−1)9.
- Only the edited field changes. Minutes never carry into hours.
- COMMIT (exactly one cycle):
  - copy the working registers into the committed registers;
  - alarmLoad=1, armed=1;
  - return to IDLE.
  - Buttons pressed during COMMIT are ignored.
- Timeout:
  - idle counter resets on any button pulse and on entering edit;
  - reaching TIMEOUT while in edit: go to IDLE, discard the working value, no alarmLoad.
- Blink:
  - counter restarts on every field entry and on every inc/dec, with blink=1;
  - blink toggles every BLINK_DIV cycles thereafter.
- Committed values are always legal BCD times. Working registers never hold an illegal time.

## Timing

- Reset values:
  - state IDLE;
  - alarm digits 0 (00:00);
  - alarmLoad 0, armed 0, editing 0, fieldSel 0, blink 0;
  - working registers 0, counters 0.
- Reset mid-edit or mid-COMMIT returns everything to reset values immediately (asynchronous); no alarmLoad is produced.
- modeBtn sampled in IDLE at edge N: editing=1 and fieldSel=0 from edge N.
- inc/dec sampled at edge N: working value updated at edge N.
- setBtn sampled in edit at edge N: COMMIT from edge N. At edge N+1 the committed outputs take the new value and alarmLoad=1 for that one cycle; alarmLoad=0 again from edge N+2.
- The consumer captures the digits on any cycle where alarmLoad=1. Digits are stable at all other times.
- setBtn sampled in IDLE at edge N: armed toggles at edge N.
- Timeout: if the last button was at edge N, exit to IDLE at edge N+TIMEOUT.

## Test plan

- Reset, then modeBtn, 3×incBtn, modeBtn, 2×decBtn, setBtn -> alarmLoad high for exactly one cycle with outputs 03:58; armed=1; editing=0.
- Hour wrap: working hour 23 plus incBtn -> 00; decBtn -> 23. Hour 09 plus incBtn -> 10. Minute 59 plus incBtn -> 00, with the hour unchanged.
- With committed 07:30, enter edit, incBtn, then modeBtn and setBtn together -> abort; outputs stay 07:30; no alarmLoad.
- Enter edit with TIMEOUT=16 and no buttons -> editing falls after 16 cycles; outputs unchanged; no alarmLoad.
- In IDLE with armed=1, setBtn -> armed=0; setBtn again -> armed=1; incBtn and decBtn in IDLE -> no change.
- Assert resetN low the cycle after setBtn in edit -> no alarmLoad; outputs 00:00; armed=0. BLINK_DIV=4 in edit -> blink pattern 1,1,1,1,0,0,0,0.

Source files
------------

// File: rtl/alarm_time_setter.sv
// alarm_time_setter: BCD alarm-time editor with 24-hour limits, commit strobe and armed flag.
// A field blink phase is produced while editing, and an idle timeout abandons the edit.
module alarm_time_setter #(
    parameter int BLINK_DIV = 500,
    parameter int TIMEOUT   = 10000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       modeBtn,
    input  logic       incBtn,
    input  logic       decBtn,
    input  logic       setBtn,
    output logic [3:0] alarmHour1,
    output logic [3:0] alarmHour0,
    output logic [3:0] alarmMin1,
    output logic [3:0] alarmMin0,
    output logic       alarmLoad,
    output logic       armed,
    output logic       editing,
    output logic       fieldSel,
    output logic       blink
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HOUR   = 2'd1;
    localparam logic [1:0] S_MIN    = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);

    logic [1:0]    r_state;
    logic [3:0]    r_wh1, r_wh0, r_wm1, r_wm0;
    logic [3:0]    r_h1, r_h0, r_m1, r_m0;
    logic          r_load, r_armed, r_blink;
    logic [TW-1:0] r_tcnt;
    logic [BW-1:0] r_bcnt;
    logic [7:0]    w_hinc, w_hdec, w_minc, w_mdec;
    logic          w_any, w_adj, w_abort, w_timeout, w_btick;

    always_comb begin
        w_any     = modeBtn | incBtn | decBtn | setBtn;
        w_adj     = incBtn ^ decBtn;
        w_abort   = modeBtn & setBtn;
        w_timeout = r_tcnt == TW'(TIMEOUT - 1);
        w_btick   = r_bcnt == BW'(BLINK_DIV - 1);
        w_hinc = ({r_wh1, r_wh0} == 8'h23) ? 8'h00 :
                 (r_wh0 == 4'd9) ? {r_wh1 + 4'd1, 4'd0} : {r_wh1, r_wh0 + 4'd1};
        w_hdec = ({r_wh1, r_wh0} == 8'h00) ? 8'h23 :
                 (r_wh0 == 4'd0) ? {r_wh1 - 4'd1, 4'd9} : {r_wh1, r_wh0 - 4'd1};
        w_minc = ({r_wm1, r_wm0} == 8'h59) ? 8'h00 :
                 (r_wm0 == 4'd9) ? {r_wm1 + 4'd1, 4'd0} : {r_wm1, r_wm0 + 4'd1};
        w_mdec = ({r_wm1, r_wm0} == 8'h00) ? 8'h59 :
                 (r_wm0 == 4'd0) ? {r_wm1 - 4'd1, 4'd9} : {r_wm1, r_wm0 - 4'd1};
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= S_IDLE;
            {r_wh1, r_wh0, r_wm1, r_wm0} <= '0;
            {r_h1, r_h0, r_m1, r_m0}     <= '0;
            r_load  <= 1'b0;
            r_armed <= 1'b0;
            r_blink <= 1'b0;
            r_tcnt  <= '0;
            r_bcnt  <= '0;
        end else begin
            r_load <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (modeBtn) begin
                        r_state <= S_HOUR;
                        {r_wh1, r_wh0, r_wm1, r_wm0} <= {r_h1, r_h0, r_m1, r_m0};
                        r_tcnt  <= '0;
                        r_bcnt  <= '0;
                        r_blink <= 1'b1;
                    end
                    if (setBtn)
                        r_armed <= ~r_armed;
                end
                S_HOUR, S_MIN: begin
                    r_tcnt  <= w_any ? '0 : r_tcnt + TW'(1);
                    r_bcnt  <= w_btick ? '0 : r_bcnt + BW'(1);
                    r_blink <= w_btick ? ~r_blink : r_blink;
                    if (w_abort) begin
                        r_state <= S_IDLE;
                        r_blink <= 1'b0;
                    end else if (setBtn) begin
                        r_state <= S_COMMIT;
                        r_blink <= 1'b0;
                    end else if (modeBtn) begin
                        r_state <= (r_state == S_HOUR) ? S_MIN : S_HOUR;
                        r_bcnt  <= '0;
                        r_blink <= 1'b1;
                    end else if (w_adj) begin
                        if (r_state == S_HOUR)
                            {r_wh1, r_wh0} <= incBtn ? w_hinc : w_hdec;
                        else
                            {r_wm1, r_wm0} <= incBtn ? w_minc : w_mdec;
                        r_bcnt  <= '0;
                        r_blink <= 1'b1;
                    end else if (w_timeout) begin
                        r_state <= S_IDLE;
                        r_blink <= 1'b0;
                    end
                end
                default: begin
                    {r_h1, r_h0, r_m1, r_m0} <= {r_wh1, r_wh0, r_wm1, r_wm0};
                    r_load  <= 1'b1;
                    r_armed <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign alarmHour1 = r_h1;
    assign alarmHour0 = r_h0;
    assign alarmMin1  = r_m1;
    assign alarmMin0  = r_m0;
    assign alarmLoad  = r_load;
    assign armed      = r_armed;
    assign editing    = (r_state == S_HOUR) || (r_state == S_MIN);
    assign fieldSel   = r_state == S_MIN;
    assign blink      = r_blink;
endmodule

// File: tb/tb_alarm_time_setter.sv
// tb_alarm_time_setter: directed scenario tests for alarm_time_setter with hand-computed expectations.
module tb_alarm_time_setter;
    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       modeBtn = 1'b0, incBtn = 1'b0, decBtn = 1'b0, setBtn = 1'b0;
    logic [3:0] alarmHour1, alarmHour0, alarmMin1, alarmMin0;
    logic       alarmLoad, armed, editing, fieldSel, blink;
    int         vecs = 0;
    int         errs = 0;
    logic [15:0] t;

    alarm_time_setter #(.BLINK_DIV(4), .TIMEOUT(16)) dut (
        .clk(clk), .resetN(resetN),
        .modeBtn(modeBtn), .incBtn(incBtn), .decBtn(decBtn), .setBtn(setBtn),
        .alarmHour1(alarmHour1), .alarmHour0(alarmHour0),
        .alarmMin1(alarmMin1), .alarmMin0(alarmMin0),
        .alarmLoad(alarmLoad), .armed(armed), .editing(editing),
        .fieldSel(fieldSel), .blink(blink)
    );

    always #5 clk = ~clk;
    assign t = {alarmHour1, alarmHour0, alarmMin1, alarmMin0};

    // One-cycle pulse on the selected buttons; returns 1 time unit after the sampling edge.
    task automatic pulse(input logic m, input logic i, input logic d, input logic s);
        @(negedge clk);
        modeBtn = m; incBtn = i; decBtn = d; setBtn = s;
        @(posedge clk);
        #1;
        modeBtn = 1'b0; incBtn = 1'b0; decBtn = 1'b0; setBtn = 1'b0;
    endtask

    task automatic pulses(input logic i, input logic d, input int n);
        for (int k = 0; k < n; k++) pulse(1'b0, i, d, 1'b0);
    endtask

    // Press set and advance into the load cycle.
    task automatic commit_wait();
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        vecs++; if (t !== 16'h0000) begin errs++; $display("FAIL reset_time got %h exp 0000", t); end
        vecs++; if ({alarmLoad, armed, editing, fieldSel, blink} !== 5'b0) begin errs++; $display("FAIL reset_flags got %b exp 00000", {alarmLoad, armed, editing, fieldSel, blink}); end
        @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic test_basic_edit();
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        vecs++; if ({editing, fieldSel, blink} !== 3'b101) begin errs++; $display("FAIL enter_edit got %b exp 101", {editing, fieldSel, blink}); end
        pulses(1'b1, 1'b0, 3);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        vecs++; if ({editing, fieldSel} !== 2'b11) begin errs++; $display("FAIL field_min got %b exp 11", {editing, fieldSel}); end
        pulses(1'b0, 1'b1, 2);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        vecs++; if ({alarmLoad, editing, t} !== {2'b00, 16'h0000}) begin errs++; $display("FAIL commit_cycle got %b/%b/%h exp 0/0/0000", alarmLoad, editing, t); end
        @(posedge clk);
        #1;
        vecs++; if (alarmLoad !== 1'b1) begin errs++; $display("FAIL load_strobe got %b exp 1", alarmLoad); end
        vecs++; if (t !== 16'h0358) begin errs++; $display("FAIL basic_time got %h exp 0358", t); end
        vecs++; if ({armed, editing} !== 2'b10) begin errs++; $display("FAIL basic_armed got %b exp 10", {armed, editing}); end
        @(posedge clk);
        #1;
        vecs++; if (alarmLoad !== 1'b0) begin errs++; $display("FAIL load_one_cycle got %b exp 0", alarmLoad); end
    endtask

    task automatic test_wrap();
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulses(1'b1, 1'b0, 20);
        commit_wait();
        vecs++; if (t !== 16'h2358) begin errs++; $display("FAIL hour_to_23 got %h exp 2358", t); end
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulses(1'b1, 1'b0, 1);
        commit_wait();
        vecs++; if (t !== 16'h0058) begin errs++; $display("FAIL hour_inc_wrap got %h exp 0058", t); end
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulses(1'b0, 1'b1, 1);
        commit_wait();
        vecs++; if (t !== 16'h2358) begin errs++; $display("FAIL hour_dec_wrap got %h exp 2358", t); end
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulses(1'b0, 1'b1, 14);
        pulses(1'b1, 1'b0, 1);
        commit_wait();
        vecs++; if (t !== 16'h1058) begin errs++; $display("FAIL hour_09_to_10 got %h exp 1058", t); end
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulses(1'b1, 1'b0, 2);
        commit_wait();
        vecs++; if (t !== 16'h1000) begin errs++; $display("FAIL min_wrap got %h exp 1000", t); end
    endtask

    task automatic test_abort();
        logic seen;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulses(1'b0, 1'b1, 3);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulses(1'b1, 1'b0, 30);
        commit_wait();
        vecs++; if (t !== 16'h0730) begin errs++; $display("FAIL setup_0730 got %h exp 0730", t); end
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulses(1'b1, 1'b0, 1);
        pulse(1'b1, 1'b0, 1'b0, 1'b1);
        seen = alarmLoad;
        vecs++; if ({editing, blink} !== 2'b00) begin errs++; $display("FAIL abort_exit got %b exp 00", {editing, blink}); end
        for (int k = 0; k < 4; k++) begin @(posedge clk); #1; seen |= alarmLoad; end
        vecs++; if (seen !== 1'b0) begin errs++; $display("FAIL abort_noload got %b exp 0", seen); end
        vecs++; if ({armed, t} !== {1'b1, 16'h0730}) begin errs++; $display("FAIL abort_keep got %b/%h exp 1/0730", armed, t); end
    endtask

    task automatic test_timeout();
        logic seen;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        seen = 1'b0;
        repeat (15) begin @(posedge clk); #1; seen |= alarmLoad; end
        vecs++; if (editing !== 1'b1) begin errs++; $display("FAIL timeout_early got %b exp 1", editing); end
        @(posedge clk);
        #1;
        vecs++; if (editing !== 1'b0) begin errs++; $display("FAIL timeout_exit got %b exp 0", editing); end
        repeat (3) begin @(posedge clk); #1; seen |= alarmLoad; end
        vecs++; if ({seen, t} !== {1'b0, 16'h0730}) begin errs++; $display("FAIL timeout_keep got %b/%h exp 0/0730", seen, t); end
    endtask

    task automatic test_armed_toggle();
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        vecs++; if (armed !== 1'b0) begin errs++; $display("FAIL arm_off got %b exp 0", armed); end
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        vecs++; if (armed !== 1'b1) begin errs++; $display("FAIL arm_on got %b exp 1", armed); end
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        vecs++; if ({armed, editing, alarmLoad, t} !== {3'b100, 16'h0730}) begin errs++; $display("FAIL idle_incdec got %b%b%b/%h exp 100/0730", armed, editing, alarmLoad, t); end
    endtask

    task automatic test_blink();
        logic [7:0] pat;
        pat = 8'b1111_0000;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            vecs++; if (blink !== pat[7-k]) begin errs++; $display("FAIL blink_%0d got %b exp %b", k, blink, pat[7-k]); end
            @(posedge clk);
            #1;
        end
        pulses(1'b1, 1'b0, 1);
        vecs++; if (blink !== 1'b1) begin errs++; $display("FAIL blink_restart got %b exp 1", blink); end
        pulse(1'b1, 1'b0, 1'b0, 1'b1);
        vecs++; if (blink !== 1'b0) begin errs++; $display("FAIL blink_idle got %b exp 0", blink); end
    endtask

    task automatic test_reset_in_commit();
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulses(1'b1, 1'b0, 1);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        resetN = 1'b0;
        #1;
        vecs++; if ({alarmLoad, armed, editing, t} !== {3'b000, 16'h0000}) begin errs++; $display("FAIL rst_commit got %b%b%b/%h exp 000/0000", alarmLoad, armed, editing, t); end
        @(posedge clk);
        #1;
        vecs++; if ({alarmLoad, t} !== {1'b0, 16'h0000}) begin errs++; $display("FAIL rst_hold got %b/%h exp 0/0000", alarmLoad, t); end
        @(negedge clk);
        resetN = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vecs++; if ({alarmLoad, armed, t} !== {2'b00, 16'h0000}) begin errs++; $display("FAIL rst_after got %b%b/%h exp 00/0000", alarmLoad, armed, t); end
    endtask

    initial begin
        test_reset();
        test_basic_edit();
        test_wrap();
        test_abort();
        test_timeout();
        test_armed_toggle();
        test_blink();
        test_reset_in_commit();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
